// File: rtl/bitpack_ssm_funnel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bitpack_ssm_funnel                                           |
// | Description : Substream funnel packer. Concatenates 0..128-bit MSB-first   |
// |               chunks into a gapless bitstream and emits 128-bit words.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bitpack_ssm_funnel #(
  parameter int SSM_IDX = 0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [127:0]      in_bits,
  input  logic [7:0]        in_len,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [127:0]      out_data,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [7:0]        fill,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              err
);

  localparam logic [127:0] c_ONES     = '1;
  localparam logic [7:0]   c_WORD_LEN = 8'd128;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // The index only tags the instance; a negative value is the one nonsensical setting.
  if (SSM_IDX < 0) begin : g_idx_invalid
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [254:0]       r_acc;
  logic [7:0]         r_fill;
  logic [CNT_W-1:0]   r_word_cnt;
  logic               r_err;

  logic               w_over;
  logic [7:0]         w_len_e;
  logic [127:0]       w_chunk;
  logic [254:0]       w_place;
  logic               w_accept;
  logic               w_drain;
  logic               w_pad;

  assign in_rdy     = ~r_fill[7] & (r_state == S_RUN);
  assign out_vld    = r_fill[7];
  assign out_data   = r_acc[254:127];
  assign flush_done = (r_state == S_DONE);
  assign fill       = r_fill;
  assign word_cnt   = r_word_cnt;
  assign err        = r_err;

  assign w_over   = (in_len > c_WORD_LEN);
  assign w_len_e  = w_over ? c_WORD_LEN : in_len;
  // Keep only the top len_e bits, then slide them to sit just below the held bits.
  assign w_chunk  = in_bits & ~(c_ONES >> w_len_e);
  assign w_place  = {w_chunk, 127'b0} >> r_fill;
  assign w_accept = in_vld & in_rdy;
  assign w_drain  = out_vld & out_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_pad       = 1'b0;
    case (r_state)
      S_RUN: begin
        if (flush_req && !in_vld) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!r_fill[7]) begin
          if (r_fill != 8'd0) begin
            w_pad = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_RUN;
      r_acc      <= '0;
      r_fill     <= 8'd0;
      r_word_cnt <= '0;
      r_err      <= 1'b0;
    end else if (start) begin
      r_state    <= S_RUN;
      r_acc      <= '0;
      r_fill     <= 8'd0;
      r_word_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc  <= r_acc | w_place;
        r_fill <= r_fill + w_len_e;
        if (w_over) begin
          r_err <= 1'b1;
        end
      end else if (w_drain) begin
        r_acc      <= {r_acc[126:0], 128'b0};
        r_fill     <= r_fill - c_WORD_LEN;
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end else if (w_pad) begin
        // Bits below fill are always zero, so padding is just a fill bump.
        r_fill <= c_WORD_LEN;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitpack_ssm_funnel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bitpack_ssm_funnel                                        |
// | Description : Self-checking bench: directed vectors plus random traffic    |
// |               compared against a bit-queue model of the packed stream.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bitpack_ssm_funnel;

  logic         clk = 1'b0;
  logic         rstn, start, in_vld, out_rdy, flush_req;
  logic [127:0] in_bits;
  logic [7:0]   in_len;
  logic         in_rdy, out_vld, flush_done, err;
  logic [127:0] out_data;
  logic [7:0]   fill;
  logic [15:0]  word_cnt;
  logic         s_in_rdy, s_out_vld, s_flush_done, s_err;
  logic [127:0] s_out_data;
  logic [7:0]   s_fill;
  logic [2:0]   s_word_cnt;

  always #5 clk = ~clk;

  bitpack_ssm_funnel #(.SSM_IDX(0), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_bits(in_bits), .in_len(in_len), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .flush_req(flush_req), .flush_done(flush_done),
    .fill(fill), .word_cnt(word_cnt), .err(err)
  );

  // Narrow counter copy so counter wrap is reachable in a short run.
  bitpack_ssm_funnel #(.SSM_IDX(1), .CNT_W(3)) dut_small (
    .clk(clk), .rstn(rstn), .start(start), .in_vld(in_vld), .in_rdy(s_in_rdy),
    .in_bits(in_bits), .in_len(in_len), .out_vld(s_out_vld), .out_rdy(out_rdy),
    .out_data(s_out_data), .flush_req(flush_req), .flush_done(s_flush_done),
    .fill(s_fill), .word_cnt(s_word_cnt), .err(s_err)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference: the pending stream as a queue of bits, earliest first.
  bit mq[$];
  int m_cnt;
  bit m_err;
  int m_ph;  // 0 idle/running, 1 flushing, 2 flush complete

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_cnt = 0;
    m_err = 0;
    m_ph  = 0;
  endfunction

  function automatic logic [127:0] model_word();
    logic [127:0] d = '0;
    for (int i = 0; i < 128; i++)
      if (i < mq.size()) d[127-i] = mq[i];
    return d;
  endfunction

  task automatic check_all();
    int sz = mq.size();
    chk("in_rdy",     in_rdy,     (sz < 128) && (m_ph == 0));
    chk("out_vld",    out_vld,    sz >= 128);
    chk("fill",       fill,       sz);
    chk("word_cnt",   word_cnt,   m_cnt % 65536);
    chk("err",        err,        m_err);
    chk("flush_done", flush_done, m_ph == 2);
    chk("out_data",   out_data,   model_word());
    chk("s_word_cnt", s_word_cnt, m_cnt % 8);
    chk("s_out_data", s_out_data, model_word());
  endtask

  function automatic void model_step();
    int  sz    = mq.size();
    int  ph_n  = m_ph;
    bit  irdy  = (sz < 128) && (m_ph == 0);
    bit  ovld  = (sz >= 128);
    if (start) begin
      model_reset();
      return;
    end
    if (m_ph == 0 && flush_req && !in_vld) ph_n = 1;
    else if (m_ph == 1 && sz == 0)         ph_n = 2;
    else if (m_ph == 2)                    ph_n = 0;
    if (in_vld && irdy) begin
      int len = (in_len > 128) ? 128 : int'(in_len);
      if (in_len > 128) m_err = 1;
      for (int i = 0; i < len; i++) mq.push_back(in_bits[127-i]);
    end else if (ovld && out_rdy) begin
      repeat (128) void'(mq.pop_front());
      m_cnt++;
    end else if (m_ph == 1 && sz > 0 && sz < 128) begin
      while (mq.size() < 128) mq.push_back(1'b0);
    end
    m_ph = ph_n;
  endfunction

  task automatic cycle();
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; in_vld = 0; out_rdy = 0; flush_req = 0; in_bits = '0; in_len = '0;
  endtask

  task automatic do_reset();
    rstn = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    logic [7:0]  len;
    logic [31:0] word;
    logic [7:0]  exp_fill;
    logic        exp_vld;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [127:0] rnd;
    int pulses;
    bit seen;
    bit fr;
    int r;

    tbl[0] = '{8'd32, 32'hAAAAAAAA, 8'd32,  1'b0};
    tbl[1] = '{8'd32, 32'h55555555, 8'd64,  1'b0};
    tbl[2] = '{8'd32, 32'hDEADBEEF, 8'd96,  1'b0};
    tbl[3] = '{8'd32, 32'h01234567, 8'd128, 1'b1};

    do_reset();

    // Reset state
    chk("rst_in_rdy",   in_rdy,   1);
    chk("rst_out_vld",  out_vld,  0);
    chk("rst_fill",     fill,     0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_err",      err,      0);

    // Four 32-bit chunks, garbage below the valid length
    for (int i = 0; i < 4; i++) begin
      rnd = rnd128();
      in_vld = 1; in_len = tbl[i].len; in_bits = {tbl[i].word, rnd[95:0]};
      cycle();
      in_vld = 0;
      chk("tbl_fill",    fill,    tbl[i].exp_fill);
      chk("tbl_out_vld", out_vld, tbl[i].exp_vld);
    end
    chk("tbl_word", out_data, 128'hAAAAAAAA_55555555_DEADBEEF_01234567);
    out_rdy = 1;
    cycle();
    out_rdy = 0;
    chk("tbl_drain_fill", fill,     0);
    chk("tbl_drain_cnt",  word_cnt, 1);

    // Two 100-bit chunks under backpressure
    in_vld = 1; in_len = 8'd100; in_bits = '1;
    cycle();
    rnd = rnd128();
    in_len = 8'd100; in_bits = {100'b0, rnd[27:0]};
    cycle();
    in_vld = 0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_fill",   fill,     200);
      chk("bp_in_rdy", in_rdy,   0);
      chk("bp_data",   out_data, {{100{1'b1}}, 28'b0});
      cycle();
    end
    out_rdy = 1;
    cycle();
    out_rdy = 0;
    chk("bp_drain_fill",   fill,   72);
    chk("bp_drain_in_rdy", in_rdy, 1);

    // Asynchronous reset while flushing with 72 bits held
    flush_req = 1;
    cycle();
    flush_req = 0;
    rstn = 0;
    #2;
    model_reset();
    chk("arst_fill",    fill,     0);
    chk("arst_out_vld", out_vld,  0);
    chk("arst_in_rdy",  in_rdy,   1);
    chk("arst_cnt",     word_cnt, 0);
    chk("arst_done",    flush_done, 0);
    @(posedge clk);
    #1;
    rstn = 1;
    check_all();

    // Flush of a 40-bit partial word
    rnd = rnd128();
    in_vld = 1; in_len = 8'd40; in_bits = {40'hFF00FF00FF, rnd[87:0]};
    cycle();
    in_vld = 0; flush_req = 1; out_rdy = 1;
    pulses = 0; seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (flush_done) begin
        pulses++;
        flush_req = 0;
      end
      if (out_vld && !seen) begin
        seen = 1;
        chk("flush_word", out_data, {40'hFF00FF00FF, 88'b0});
      end
      cycle();
    end
    out_rdy = 0;
    chk("flush_word_seen", seen,   1);
    chk("flush_pulses",    pulses, 1);
    chk("flush_fill",      fill,   0);

    // Oversized length clamps to 128 and sets sticky err
    in_vld = 1; in_len = 8'd200; in_bits = '1;
    cycle();
    in_vld = 0;
    chk("over_err",  err,      1);
    chk("over_fill", fill,     128);
    chk("over_vld",  out_vld,  1);
    chk("over_data", out_data, '1);
    out_rdy = 1;
    cycle();
    out_rdy = 0;
    chk("over_err_sticky", err, 1);

    // start overrides a same-cycle drain
    in_vld = 1; in_len = 8'd128; in_bits = rnd128();
    cycle();
    in_vld = 0; out_rdy = 1; start = 1;
    cycle();
    start = 0; out_rdy = 0;
    chk("start_fill", fill,     0);
    chk("start_cnt",  word_cnt, 0);
    chk("start_err",  err,      0);

    // Counter wrap on the 3-bit instance
    for (int w = 1; w <= 8; w++) begin
      in_vld = 1; in_len = 8'd128; in_bits = rnd128();
      cycle();
      in_vld = 0; out_rdy = 1;
      cycle();
      out_rdy = 0;
      if (w == 7) chk("wrap_pre",  s_word_cnt, 7);
      if (w == 8) chk("wrap_zero", s_word_cnt, 0);
    end
    chk("wrap_main", word_cnt, 8);

    // Random traffic against the model
    do_reset();
    fr = 0;
    for (int k = 0; k < 4000; k++) begin
      start = ($urandom_range(0, 299) == 0);
      if (start || m_ph == 2) fr = 0;
      else if (!fr && $urandom_range(0, 49) == 0) fr = 1;
      flush_req = fr;
      in_vld  = ($urandom_range(0, 9) < 7);
      out_rdy = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 9);
      if (r == 0)      in_len = 8'($urandom_range(129, 255));
      else if (r == 1) in_len = 8'd0;
      else if (r == 2) in_len = 8'd128;
      else             in_len = 8'($urandom_range(1, 127));
      in_bits = rnd128();
      cycle();
    end
    idle_inputs();
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
